y86_stage_sequencer: RTL and testbench
======================================

Name: y86_stage_sequencer

Overview:
- Parametrised multi-cycle controller that replaces the free-running testbench clock loop of the single-cycle processor top.
- Steps one instruction through six one-cycle phases: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD.
- Drives a one-hot stage enable per phase, owns the architectural PC register, and halts on a non-AOK status or an instruction budget.
- Supports free-run and single-step modes so benches and debug logic can advance one instruction at a time.

Parameters:
- ADDR_W, 64, width of PC and pc_next.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 32, width of instr_count and cycle_count.
- MAX_INSTR, 0, instruction budget; 0 means unlimited.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start pulse; sampled only in IDLE.
- step_mode  in  1  1 = pause after every instruction.
- step  in  1  advance pulse; sampled only in PAUSE.
- stat_in  in  2  status from memory stage: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- pc_next  in  ADDR_W  new PC from the pc_update logic.
- pc  out  ADDR_W  architectural PC presented to fetch.
- en_fetch, en_decode, en_execute, en_memory, en_writeback, pc_we  out  1 each  one-hot stage enables.
- busy  out  1  high in any of the six phase states.
- halted  out  1  high in HALT.
- halt_code  out  2  stat_in value that caused the halt.
- timeout  out  1  1 = halt caused by the MAX_INSTR budget.
- instr_count  out  CNT_W  number of retired instructions.
- cycle_count  out  CNT_W  number of cycles spent in phase states.

Behaviour:
- Reset (asynchronous, any state, including mid-instruction) sets:
  - state = IDLE, pc = RESET_PC.
  - all enables = 0, busy = 0, halted = 0, timeout = 0.
  - halt_code = 0, instr_count = 0, cycle_count = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE, HALT. Enables are registered and decoded from state.
- Enable mapping: en_fetch=FETCH, en_decode=DECODE, en_execute=EXECUTE, en_memory=MEMORY, en_writeback=WRITEBACK, pc_we=PCUPD.
- At most one enable is high in any cycle. All enables are 0 in IDLE, PAUSE and HALT.
- IDLE: run=1 goes to FETCH; otherwise stay.
- FETCH through WRITEBACK each last exactly one cycle and advance in order.
- PCUPD, one cycle. stat_in is sampled here, and the priority order is:
  1. stat_in != 0: go to HALT; halt_code = stat_in; pc unchanged; instr_count unchanged.
  2. Else: pc <= pc_next; instr_count += 1.
     - Budget reached (MAX_INSTR != 0 and the new count == MAX_INSTR): go to HALT with timeout = 1 and halt_code = 0.
     - Else if step_mode = 1: go to PAUSE.
     - Else: go to FETCH.
- Instruction latency is 6 cycles in free-run mode. The first en_fetch is high the cycle after run is sampled.
- PAUSE: step=1 goes to FETCH. run is ignored. step_mode going to 0 while in PAUSE does not auto-resume; a step pulse is still required.
- HALT is sticky until reset. run and step are ignored; all outputs hold.
- cycle_count increments on every cycle spent in FETCH through PCUPD and saturates at all-ones.
- instr_count wraps modulo 2^CNT_W. The budget test is exact equality.
- run and step are level-sampled; a multi-cycle pulse is treated as one request per qualifying state entry.

Test Plan:
- Reset, then run=1 for 1 cycle with stat_in=0 and pc_next=pc+10 -> en_fetch, en_decode, en_execute, en_memory, en_writeback, pc_we each high 1 cycle in order; pc=0x0A at the cycle after pc_we; instr_count=1; cycle_count=6.
- Free-run with pc_next=pc+2 for 5 instructions -> pc=0x0A, instr_count=5, cycle_count=30, and no idle cycle between PCUPD and FETCH.
- stat_in=1 (HLT) during the 3rd PCUPD -> halted=1, halt_code=1, instr_count=2, pc frozen; a later run=1 causes no enables.
- step_mode=1 -> PAUSE after each PCUPD; holding step low for 20 cycles keeps pc and cycle_count fixed; a step pulse starts exactly one further 6-cycle instruction.
- MAX_INSTR=3 -> halted=1, timeout=1, halt_code=0, instr_count=3 after 18 phase cycles.
- Assert reset during EXECUTE -> all outputs return to reset values asynchronously, without waiting for clk; state=IDLE and pc=RESET_PC.

Source files
------------

// File: rtl/y86_stage_sequencer.sv
// rtl/y86_stage_sequencer.sv - six-phase multi-cycle stage sequencer for the Y86 core
//
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and
// PCUPD, one cycle each. Owns the architectural PC and retires or halts in PCUPD.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   run               start request, sampled in IDLE only
//   step_mode, step   pause after each instruction / resume request in PAUSE
//   stat_in           memory-stage status (0 AOK, 1 HLT, 2 ADR, 3 INS)
//   pc_next           next PC from the pc_update logic
//   pc                architectural PC presented to fetch
//   en_* / pc_we      one-hot registered stage enables
//   busy, halted      in a phase state / in HALT
//   halt_code,timeout halt cause (status value / instruction budget)
//   instr_count       retired instructions (wraps)
//   cycle_count       cycles spent in phase states (saturates)

module y86_stage_sequencer #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                CNT_W     = 32,
  parameter int                MAX_INSTR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step_mode,
  input  logic              step,
  input  logic [1:0]        stat_in,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic              en_fetch,
  output logic              en_decode,
  output logic              en_execute,
  output logic              en_memory,
  output logic              en_writeback,
  output logic              pc_we,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        halt_code,
  output logic              timeout,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_PAUSE,
    S_HALT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        halt_code_q, halt_code_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [5:0]        en_q, en_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              in_phase;
  logic [CNT_W-1:0]  instr_inc;

  assign in_phase  = (state_q != S_IDLE) && (state_q != S_PAUSE) && (state_q != S_HALT);
  assign instr_inc = instr_count_q + 1'b1;

  // Next-state, PC and counters.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    halt_code_d   = halt_code_q;
    timeout_d     = timeout_q;
    instr_count_d = instr_count_q;
    cycle_count_d = cycle_count_q;

    if (in_phase && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      S_MEMORY:    state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if (stat_in != 2'd0) begin
          // Faulting instruction does not retire: PC and count stay put.
          state_d     = S_HALT;
          halt_code_d = stat_in;
        end else begin
          pc_d          = pc_next;
          instr_count_d = instr_inc;
          if ((MAX_INSTR != 0) && (instr_inc == MAX_CNT)) begin
            state_d     = S_HALT;
            timeout_d   = 1'b1;
            halt_code_d = 2'd0;
          end else if (step_mode) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_PAUSE:     if (step) state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    en_d     = 6'b0;
    busy_d   = 1'b0;
    halted_d = 1'b0;
    case (state_d)
      S_FETCH:     en_d = 6'b100000;
      S_DECODE:    en_d = 6'b010000;
      S_EXECUTE:   en_d = 6'b001000;
      S_MEMORY:    en_d = 6'b000100;
      S_WRITEBACK: en_d = 6'b000010;
      S_PCUPD:     en_d = 6'b000001;
      default:     en_d = 6'b0;
    endcase
    busy_d   = (en_d != 6'b0);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      halt_code_q   <= 2'd0;
      timeout_q     <= 1'b0;
      instr_count_q <= '0;
      cycle_count_q <= '0;
      en_q          <= 6'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halt_code_q   <= halt_code_d;
      timeout_q     <= timeout_d;
      instr_count_q <= instr_count_d;
      cycle_count_q <= cycle_count_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign pc           = pc_q;
  assign en_fetch     = en_q[5];
  assign en_decode    = en_q[4];
  assign en_execute   = en_q[3];
  assign en_memory    = en_q[2];
  assign en_writeback = en_q[1];
  assign pc_we        = en_q[0];
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign halt_code    = halt_code_q;
  assign timeout      = timeout_q;
  assign instr_count  = instr_count_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// tb/tb_y86_stage_sequencer.sv - directed self-checking bench for y86_stage_sequencer

module tb_y86_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        run_b = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [1:0]  stat_in = 2'd0;
  logic [63:0] pc_inc = 64'd0;
  logic [63:0] pc_next, pc_next_b;

  logic [63:0] pc, pc_b;
  logic        en_fetch, en_decode, en_execute, en_memory, en_writeback, pc_we;
  logic        en_fetch_b, en_decode_b, en_execute_b, en_memory_b, en_writeback_b, pc_we_b;
  logic        busy, halted, timeout, busy_b, halted_b, timeout_b;
  logic [1:0]  halt_code, halt_code_b;
  logic [31:0] instr_count, cycle_count, instr_count_b, cycle_count_b;

  int vectors = 0;
  int miscompares = 0;

  wire [5:0] ens = {en_fetch, en_decode, en_execute, en_memory, en_writeback, pc_we};

  assign pc_next   = pc + pc_inc;
  assign pc_next_b = pc_b + 64'd2;

  always #5 clk = ~clk;

  y86_stage_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
    .stat_in(stat_in), .pc_next(pc_next), .pc(pc),
    .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
    .en_memory(en_memory), .en_writeback(en_writeback), .pc_we(pc_we),
    .busy(busy), .halted(halted), .halt_code(halt_code), .timeout(timeout),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  y86_stage_sequencer #(.MAX_INSTR(3)) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .step_mode(1'b0), .step(1'b0),
    .stat_in(2'd0), .pc_next(pc_next_b), .pc(pc_b),
    .en_fetch(en_fetch_b), .en_decode(en_decode_b), .en_execute(en_execute_b),
    .en_memory(en_memory_b), .en_writeback(en_writeback_b), .pc_we(pc_we_b),
    .busy(busy_b), .halted(halted_b), .halt_code(halt_code_b), .timeout(timeout_b),
    .instr_count(instr_count_b), .cycle_count(cycle_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; run_b = 1'b0; step = 1'b0; stat_in = 2'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step_mode = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if ({ens, busy, halted, timeout, halt_code} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=0", {ens, busy, halted, timeout, halt_code});
    end
    vectors++;
    if ({pc, instr_count, cycle_count} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_regs pc=%0h ic=%0d cc=%0d exp=0/0/0", pc, instr_count, cycle_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_instr();
    logic [5:0] exp_en;
    do_reset();
    step_mode = 1'b1;
    pc_inc = 64'd10;
    run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      run = 1'b0;
      exp_en = 6'b100000 >> k;
      vectors++;
      if (ens !== exp_en) begin
        miscompares++;
        $display("FAIL single_en_phase%0d got=%b exp=%b", k, ens, exp_en);
      end
    end
    tick();
    vectors++;
    if (pc !== 64'h0A || instr_count !== 32'd1 || cycle_count !== 32'd6 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_retire pc=%0h ic=%0d cc=%0d busy=%b exp=a/1/6/0",
               pc, instr_count, cycle_count, busy);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    step_mode = 1'b0;
    pc_inc = 64'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    vectors++;
    if (pc !== 64'h0A || instr_count !== 32'd5 || cycle_count !== 32'd30) begin
      miscompares++;
      $display("FAIL free_run_counts pc=%0h ic=%0d cc=%0d exp=a/5/30", pc, instr_count, cycle_count);
    end
    vectors++;
    if (ens !== 6'b100000) begin
      miscompares++;
      $display("FAIL free_run_back_to_back en=%b exp=100000", ens);
    end
  endtask

  task automatic test_halt();
    do_reset();
    step_mode = 1'b0;
    pc_inc = 64'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    vectors++;
    if (pc_we !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_third_pcupd pc_we=%b exp=1", pc_we);
    end
    stat_in = 2'd1;
    tick();
    stat_in = 2'd0;
    vectors++;
    if (halted !== 1'b1 || halt_code !== 2'd1 || timeout !== 1'b0 || instr_count !== 32'd2 || pc !== 64'd4) begin
      miscompares++;
      $display("FAIL halt_state h=%b code=%0d to=%b ic=%0d pc=%0h exp=1/1/0/2/4",
               halted, halt_code, timeout, instr_count, pc);
    end
    run = 1'b1;
    step = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (ens !== 6'd0 || busy !== 1'b0 || halted !== 1'b1 || pc !== 64'd4) begin
        miscompares++;
        $display("FAIL halt_sticky c=%0d en=%b busy=%b h=%b pc=%0h exp=0/0/1/4", c, ens, busy, halted, pc);
      end
    end
    run = 1'b0;
    step = 1'b0;
  endtask

  task automatic test_step_mode();
    do_reset();
    step_mode = 1'b1;
    pc_inc = 64'd4;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (pc !== 64'd4 || cycle_count !== 32'd6 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL step_pause pc=%0h cc=%0d busy=%b exp=4/6/0", pc, cycle_count, busy);
    end
    step_mode = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    run = 1'b0;
    vectors++;
    if (pc !== 64'd4 || cycle_count !== 32'd6 || busy !== 1'b0 || ens !== 6'd0) begin
      miscompares++;
      $display("FAIL step_hold pc=%0h cc=%0d busy=%b en=%b exp=4/6/0/0", pc, cycle_count, busy, ens);
    end
    step_mode = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    vectors++;
    if (ens !== 6'b100000) begin
      miscompares++;
      $display("FAIL step_fetch en=%b exp=100000", ens);
    end
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (pc !== 64'd8 || instr_count !== 32'd2 || cycle_count !== 32'd12 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL step_one_instr pc=%0h ic=%0d cc=%0d busy=%b exp=8/2/12/0",
               pc, instr_count, cycle_count, busy);
    end
  endtask

  task automatic test_budget();
    do_reset();
    run_b = 1'b1;
    tick();
    run_b = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    vectors++;
    if (pc_we_b !== 1'b1 || halted_b !== 1'b0) begin
      miscompares++;
      $display("FAIL budget_last_pcupd pc_we=%b h=%b exp=1/0", pc_we_b, halted_b);
    end
    tick();
    vectors++;
    if (halted_b !== 1'b1 || timeout_b !== 1'b1 || halt_code_b !== 2'd0 ||
        instr_count_b !== 32'd3 || cycle_count_b !== 32'd18 || pc_b !== 64'd6) begin
      miscompares++;
      $display("FAIL budget_halt h=%b to=%b code=%0d ic=%0d cc=%0d pc=%0h exp=1/1/0/3/18/6",
               halted_b, timeout_b, halt_code_b, instr_count_b, cycle_count_b, pc_b);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step_mode = 1'b0;
    pc_inc = 64'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    vectors++;
    if (en_execute !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre_execute en=%b exp=001000", ens);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (ens !== 6'd0 || busy !== 1'b0 || pc !== 64'd0 || cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset en=%b busy=%b pc=%0h cc=%0d ic=%0d exp=0", ens, busy, pc, cycle_count, instr_count);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || ens !== 6'd0) begin
      miscompares++;
      $display("FAIL async_idle busy=%b en=%b exp=0/0", busy, ens);
    end
  endtask

  initial begin
    test_reset();
    test_single_instr();
    test_free_run();
    test_halt();
    test_step_mode();
    test_budget();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
